wb_write_queue: RTL
===================

Name: wb_write_queue

Overview:
- Writeback buffer that sits directly upstream of the dual-write-port register file.
- Accepts completed results from two execution sources, A (ALU) and B (MEM), and stores them in program order in a small circular queue.
- Drains up to two entries per cycle onto the register file's two write ports.
- Preserves last-writer-wins ordering by always placing the older entry on port 1 and the younger on port 2. The register file lets port 2 win on an equal address.

Parameters:
DEPTH, 8, number of queue entries; power of two, minimum 4
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
a_valid  in  1  source A result valid
a_ready  out  1  source A may transfer this cycle
a_addr  in  AW  source A destination register
a_data  in  DW  source A result
b_valid  in  1  source B result valid
b_ready  out  1  source B may transfer this cycle
b_addr  in  AW  source B destination register
b_data  in  DW  source B result
hold  in  1  suppress draining this cycle
we1  out  1  write enable, port 1 (older entry)
wa1  out  AW  write address, port 1
wd1  out  DW  write data, port 1
we2  out  1  write enable, port 2 (younger entry)
wa2  out  AW  write address, port 2
wd2  out  DW  write data, port 2
count  out  clog2(DEPTH)+1  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (async, rst_n low):
  - head, tail and count go to 0 immediately.
  - full=0, empty=1, we1=0, we2=0, a_ready=1, b_ready=1.
  - In-flight entries are discarded.
  - Deassertion takes effect at the next edge.
- Readiness depends only on registered count, never on valid:
  - a_ready = (count <= DEPTH-1).
  - b_ready = (count <= DEPTH-2).
  - No same-cycle bypass of free slots released by draining.
- Transfer rules:
  - A transfers when a_valid && a_ready; B transfers when b_valid && b_ready.
  - When both transfer in the same cycle, A is older.
  - A transferred entry with addr==0 is accepted and silently dropped: not enqueued, no slot used.
  - If A is dropped (addr 0) and B is kept, B takes the tail slot.
- Enqueue:
  - kept entries write to tail, then tail+1 in order.
  - tail advances by the number kept (0..2), modulo DEPTH.
- Drain is combinational from registered queue state:
  - we1 = !hold && count>=1; {wa1,wd1} = entry[head].
  - we2 = !hold && count>=2; {wa2,wd2} = entry[head+1 mod DEPTH].
  - head advances by we1+we2 at the edge.
  - When we is 0, the corresponding wa/wd hold the head-slot contents (don't-care to the consumer).
- Equal-address pair (wa1==wa2): both are issued; the port-2 (younger) value lands, which is correct. No merging.
- Latency: an entry accepted at edge N appears on a write port no earlier than the cycle after edge N (minimum 1 cycle). There is no enqueue-to-port bypass.
- Occupancy: count_next = count + kept − drained, updated every edge.
  - Enqueue and drain in the same cycle are legal at any occupancy.
  - When full: neither ready is asserted, and draining proceeds.
- Wrap-around: head and tail are log2(DEPTH)-bit and wrap naturally. Two-entry accesses that straddle index DEPTH-1→0 must work.
- Holding and backpressure:
  - hold freezes head.
  - The queue keeps accepting new entries while space remains.
  - A source with valid high and ready low must keep addr/data stable; the queue does not check this.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - count never underflows below 0.
  - we2 implies we1.

Test Plan:
- Reset, then A={3,0xAAAA0001} one cycle → next cycle we1=1, wa1=3, wd1=0xAAAA0001, we2=0; then count=0, empty=1.
- Same cycle A={7,0x11}, B={7,0x22} → next cycle we1/wa1=7/0x11 and we2/wa2=7/0x22; after the edge the register file holds r7=0x22.
- A={0,0x55}, B={4,0x66} → only one entry enqueued (count=1); we1 with wa1=4, wd1=0x66; r0 is never written.
- hold=1, push pairs until full → full=1 at count=8, a_ready=0, b_ready=0 at count 8, b_ready=0 already at count 7; release hold → 2 entries drained per cycle in order, empty after 4 cycles.
- Pre-position head=7 by cycling, keep ≥2 entries, release hold → pair read from slots 7 and 0 in order; tail wraps likewise; data integrity checked for 100 random entries against a reference model.
- Assert rst_n low mid-stream with count=5 → outputs go to reset values without waiting for clk; after release no stale writes are issued.

Source files
------------

// File: rtl/wb_write_queue_if.sv
// Handshake and register-file write bundle for wb_write_queue.
// The master drives results and hold. The slave (the queue) drives readies, write ports and occupancy.
interface wb_write_queue_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;

    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    logic          hold;

    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          we2;
    logic [AW-1:0] wa2;
    logic [DW-1:0] wd2;

    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold,
        input  a_ready, b_ready, we1, wa1, wd1, we2, wa2, wd2, count, full, empty
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold,
        output a_ready, b_ready, we1, wa1, wd1, we2, wa2, wd2, count, full, empty
    );
endinterface

// File: rtl/wb_write_queue.sv
// Program-order writeback queue: two results in per cycle, and up to two drained per cycle to the register file.
// Latency: at least 1 cycle from acceptance to a write port. Readiness comes only from the registered count.
// Backpressure: A needs one free slot and B needs two. Hold freezes draining but not accepting.
module wb_write_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_write_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LIM_A   = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIM_B   = CW'(DEPTH - 2);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    logic [PW-1:0] b_slot;
    logic          a_keep;
    logic          b_keep;
    logic [1:0]    n_keep;
    logic [1:0]    n_drain;

    // B may be accepted only when two slots are free, so the A+B pair always fits.
    assign bus.a_ready = (cnt <= LIM_A);
    assign bus.b_ready = (cnt <= LIM_B);

    // Writes to r0 are architecturally void, so they are consumed without taking a slot.
    assign a_keep  = bus.a_valid && bus.a_ready && (bus.a_addr != '0);
    assign b_keep  = bus.b_valid && bus.b_ready && (bus.b_addr != '0);
    assign n_keep  = {1'b0, a_keep} + {1'b0, b_keep};

    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);
    assign b_slot  = a_keep ? tail_p1 : tail;

    // Older entry goes to port 1. The register file gives port 2 priority on equal addresses.
    assign bus.we1 = !bus.hold && (cnt >= CW'(1));
    assign bus.we2 = !bus.hold && (cnt >= CW'(2));
    assign bus.wa1 = addr_mem[head];
    assign bus.wd1 = data_mem[head];
    assign bus.wa2 = addr_mem[head_p1];
    assign bus.wd2 = data_mem[head_p1];
    assign n_drain = {1'b0, bus.we1} + {1'b0, bus.we2};

    assign bus.count = cnt;
    assign bus.full  = (cnt == DEPTH_C);
    assign bus.empty = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + PW'(n_drain);
            tail <= tail + PW'(n_keep);
            cnt  <= cnt + CW'(n_keep) - CW'(n_drain);
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (a_keep) begin
            addr_mem[tail] <= bus.a_addr;
            data_mem[tail] <= bus.a_data;
        end
        if (b_keep) begin
            addr_mem[b_slot] <= bus.b_addr;
            data_mem[b_slot] <= bus.b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (cnt <= DEPTH_C);
            assert ({1'b0, cnt} + (CW+1)'(n_keep) >= (CW+1)'(n_drain));
            assert (!bus.we2 || bus.we1);
        end
    end
endmodule
